imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the PC/instruction-memory pair and the decode stage.
- Owns the PC and drives the address into the combinational instruction ROM.
- Captures the returned word into an IF/ID output register and hands it to decode with a valid/ready handshake.
- Handles start, decode back-pressure, branch/jump redirect and halting at the end of the ROM address window.

---
 rtl/imem_fetch_ctrl.sv | 80 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM, and
// hands captured words to decode through a registered valid/ready stage.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd2,
  parameter logic [31:0] PC_LIMIT = 32'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        slot_free;

  assign slot_free  = ~if_valid | id_ready;
  assign imem_pc    = pc;
  assign if_pc_next = if_pc + PC_STEP;
  assign halted     = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= redirect_pc;
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            // squash the held word even under back-pressure
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (slot_free) begin
            if (pc >= PC_LIMIT) begin
              state    <= ST_HALT;
              if_valid <= 1'b0;
            end else begin
              if_instr <= imem_instr;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + PC_STEP;
              if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl checked against a cycle-level
// behavioural model of the fetch rules.
module tb_imem_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic [31:0] imem_instr;
  logic [31:0] imem_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic        halted;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  // model state
  logic        m_run, m_halt, m_v;
  logic [31:0] m_pc, m_instr, m_ipc;
  int          m_cnt;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .imem_instr(imem_instr),
    .imem_pc(imem_pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // word at pc 12 is all-zero to exercise the NOP case
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'd12) ? 32'd0 : (32'hA000_0000 | a);
  endfunction

  assign imem_instr = rom(imem_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("imem_pc", imem_pc, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_next", if_pc_next, m_ipc + 32'd2);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_count", {16'd0, fetch_count}, m_cnt);
  endtask

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_halt = 0; m_v = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (start) begin m_pc = 0; m_halt = 0; m_run = 1; end
    end else if (!m_run) begin
      if (redirect_valid) m_pc = redirect_pc;
      if (start) m_run = 1;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_v = 0;
    end else if (!m_v || id_ready) begin
      if (m_pc >= 32'd64) begin
        m_halt = 1; m_run = 0; m_v = 0;
      end else begin
        m_instr = rom(m_pc); m_ipc = m_pc; m_v = 1; m_pc = m_pc + 32'd2;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  // one clock: check current outputs, apply new inputs, advance the model
  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic r, input logic do_chk = 1'b1);
    @(negedge clk);
    if (do_chk) check_all();
    start = s; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy; rst = r;
    model_step();
  endtask

  initial begin
    // reset for 2 cycles, then idle
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0);

    // stream to the limit with decode always ready
    cyc(1, 0, 0, 1, 0);
    repeat (40) cyc(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_count", {16'd0, fetch_count}, 32'd32);
    chk("halt_pc", imem_pc, 32'd64);
    // redirect ignored while halted, start restarts from 0
    cyc(0, 1, 32'd20, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);

    // back-pressure and redirect under stall
    cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'd40, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);

    // reset mid-run, then refetch
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, rv, rdy, r;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 32'($urandom_range(0, 40)) * 32'd2;
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      cyc(s, rv, rpc, rdy, r);
    end
    cyc(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
